// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - round-robin arbiter sharing one ROM among NREQ requesters
// Optional feature macro: ROM_ARBITER_FIXED_PRIO_EN (requester 0 fixed highest
// priority, requesters 1..NREQ-1 round-robin among themselves).
module rom_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADDRW   = 8,
  parameter int WIDTH   = 8,
  parameter int ROM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*ADDRW-1:0] req_addr,
  output logic [NREQ-1:0]       gnt,
  output logic [ADDRW-1:0]      rom_addr,
  input  logic [WIDTH-1:0]      rom_data,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PTRW-1:0] LAST_IDX = PTRW'(NREQ - 1);

  logic [PTRW-1:0]  r_ptr;
  logic [ADDRW-1:0] r_rom_addr;
  logic [NREQ-1:0]  r_tag [ROM_LAT];

  logic [NREQ-1:0]  w_gnt_raw;
  logic [PTRW-1:0]  w_win;
  logic             w_found;
  logic             w_grant_any;
  logic [ADDRW-1:0] w_sel_addr;
  logic [ADDRW-1:0] w_addr_arr [NREQ];
  logic             w_busy;

  // Unpack the flattened request address bus into one entry per requester.
  genvar g;
  generate
    for (g = 0; g < NREQ; g++) begin : g_unpack
      assign w_addr_arr[g] = req_addr[g*ADDRW +: ADDRW];
    end
  endgenerate

`ifdef ROM_ARBITER_FIXED_PRIO_EN
  // Requester 0 wins outright; others are searched from ptr over 1..NREQ-1.
  always_comb begin
    int base;
    int idx;
    w_gnt_raw = '0;
    w_win     = '0;
    w_found   = 1'b0;
    base      = (r_ptr == '0) ? 1 : int'(r_ptr);
    idx       = 0;
    if (req[0]) begin
      w_gnt_raw[0] = 1'b1;
      w_found      = 1'b1;
    end else begin
      for (int k = 0; k < NREQ - 1; k++) begin
        idx = base + k;
        if (idx >= NREQ) idx = idx - (NREQ - 1);
        if (!w_found && req[PTRW'(idx)]) begin
          w_found               = 1'b1;
          w_win                 = PTRW'(idx);
          w_gnt_raw[PTRW'(idx)] = 1'b1;
        end
      end
    end
  end
`else
  // Pure round-robin: first requesting index at or after ptr, wrapping.
  always_comb begin
    int idx;
    w_gnt_raw = '0;
    w_win     = '0;
    w_found   = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && req[PTRW'(idx)]) begin
        w_found               = 1'b1;
        w_win                 = PTRW'(idx);
        w_gnt_raw[PTRW'(idx)] = 1'b1;
      end
    end
  end
`endif

  // Grant is suppressed while reset is held so nothing enters the pipeline.
  always_comb begin
    w_grant_any = rst_n & w_found;
    gnt         = rst_n ? w_gnt_raw : '0;
    w_sel_addr  = w_addr_arr[w_win];
    rom_addr    = w_grant_any ? w_sel_addr : r_rom_addr;
  end

  // Rotate the search pointer past the winner; hold it when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_grant_any) begin
`ifdef ROM_ARBITER_FIXED_PRIO_EN
      // Grants to requester 0 leave the rotation among 1..NREQ-1 untouched.
      if (w_win != '0) begin
        r_ptr <= (w_win == LAST_IDX) ? PTRW'(1) : w_win + PTRW'(1);
      end
`else
      r_ptr <= (w_win == LAST_IDX) ? '0 : w_win + PTRW'(1);
`endif
    end
  end

  // Remember the last granted address so the ROM address holds when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rom_addr <= '0;
    end else if (w_grant_any) begin
      r_rom_addr <= w_sel_addr;
    end
  end

  // Tag pipeline carries the one-hot owner alongside the ROM read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < ROM_LAT; s++) r_tag[s] <= '0;
    end else begin
      r_tag[0] <= gnt;
      for (int s = 1; s < ROM_LAT; s++) r_tag[s] <= r_tag[s-1];
    end
  end

  // Busy whenever any stage still holds an outstanding read.
  always_comb begin
    w_busy = 1'b0;
    for (int s = 0; s < ROM_LAT; s++) w_busy = w_busy | (|r_tag[s]);
  end

  assign rsp_valid = r_tag[ROM_LAT-1];
  assign rsp_data  = rom_data;
  assign busy      = w_busy;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - directed self-checking bench for rom_arbiter (ROM_LAT 1 and 3)
module tb_rom_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_addr;

  logic [3:0]  gnt1, rsp_valid1, gnt3, rsp_valid3;
  logic [7:0]  rom_addr1, rom_data1, rsp_data1;
  logic [7:0]  rom_addr3, rom_data3, rsp_data3;
  logic        busy1, busy3;

  int n_cmp;
  int n_fail;

  logic [7:0] a1_q;
  logic [7:0] a3_q [3];

  rom_arbiter #(.NREQ(4), .ADDRW(8), .WIDTH(8), .ROM_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
    .gnt(gnt1), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .busy(busy1)
  );

  rom_arbiter #(.NREQ(4), .ADDRW(8), .WIDTH(8), .ROM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
    .gnt(gnt3), .rom_addr(rom_addr3), .rom_data(rom_data3),
    .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .busy(busy3)
  );

  function automatic logic [7:0] romf(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'hC3;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM models: address sampled at the edge, data out after 1 or 3 clocks.
  always @(posedge clk) begin
    a1_q    <= rom_addr1;
    a3_q[0] <= rom_addr3;
    a3_q[1] <= a3_q[0];
    a3_q[2] <= a3_q[1];
  end
  assign rom_data1 = romf(a1_q);
  assign rom_data3 = romf(a3_q[2]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [7:0] a);
    req_addr[i*8 +: 8] = a;
  endtask

  initial begin
    logic [3:0] exp_g, prev_g;
    logic [7:0] exp_a, prev_a;
    n_cmp    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req      = 4'b0000;
    req_addr = 32'h0;
    prev_g   = 4'b0;
    prev_a   = 8'h0;

    // Reset state; gnt forced low even with all requests high.
    repeat (2) @(negedge clk);
    req = 4'b1111;
    #1;
    chk("rst_gnt1", 32'(gnt1), 32'h0);
    chk("rst_gnt3", 32'(gnt3), 32'h0);
    chk("rst_rom_addr", 32'(rom_addr1), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid1), 32'h0);
    chk("rst_busy", 32'(busy1), 32'h0);

    // Single request from requester 0.
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0001;
    set_addr(0, 8'h10);
    #1;
    chk("single_gnt", 32'(gnt1), 32'h1);
    chk("single_rom_addr", 32'(rom_addr1), 32'h10);
    @(negedge clk);
    req = 4'b0000;
    #1;
    chk("single_rsp_valid", 32'(rsp_valid1), 32'h1);
    chk("single_rsp_data", 32'(rsp_data1), 32'(romf(8'h10)));
    chk("single_busy", 32'(busy1), 32'h1);
    chk("single_gnt_idle", 32'(gnt1), 32'h0);
    @(negedge clk);
    #1;
    chk("single_rsp_done", 32'(rsp_valid1), 32'h0);
    chk("single_busy_done", 32'(busy1), 32'h0);
    chk("lat3_busy", 32'(busy3), 32'h1);
    chk("lat3_rsp_early", 32'(rsp_valid3), 32'h0);
    @(negedge clk);
    #1;
    chk("lat3_rsp_valid", 32'(rsp_valid3), 32'h1);
    chk("lat3_rsp_data", 32'(rsp_data3), 32'(romf(8'h10)));

    // Full contention right after a fresh reset.
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1111;
    for (int i = 0; i < 4; i++) set_addr(i, 8'h20 + 8'(i));
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
`ifdef ROM_ARBITER_FIXED_PRIO_EN
      exp_g = 4'b0001;
      exp_a = 8'h20;
`else
      exp_g = 4'b0001 << i;
      exp_a = 8'h20 + 8'(i);
`endif
      chk($sformatf("cont_gnt%0d", i), 32'(gnt1), 32'(exp_g));
      chk($sformatf("cont_addr%0d", i), 32'(rom_addr1), 32'(exp_a));
      if (i > 0) begin
        chk($sformatf("cont_rsp%0d", i), 32'(rsp_valid1), 32'(prev_g));
        chk($sformatf("cont_data%0d", i), 32'(rsp_data1), 32'(romf(prev_a)));
      end
      prev_g = exp_g;
      prev_a = exp_a;
    end
    @(negedge clk);
    req = 4'b0000;
    #1;
    chk("cont_rsp_last", 32'(rsp_valid1), 32'(prev_g));
    chk("cont_data_last", 32'(rsp_data1), 32'(romf(prev_a)));

`ifdef ROM_ARBITER_FIXED_PRIO_EN
    // Requester 0 drops: the others rotate among themselves.
    @(negedge clk);
    req = 4'b1110;
    #1;
    chk("fix_rr0", 32'(gnt1), 32'h2);
    @(negedge clk);
    #1;
    chk("fix_rr1", 32'(gnt1), 32'h4);
    @(negedge clk);
    #1;
    chk("fix_rr2", 32'(gnt1), 32'h8);
`endif

    // Pointer wrap: grant 3, then 1001 gives 0 then 3.
    @(negedge clk);
    req = 4'b1000;
    #1;
    chk("wrap_gnt3", 32'(gnt1), 32'h8);
    @(negedge clk);
    req = 4'b1001;
    #1;
    chk("wrap_gnt0", 32'(gnt1), 32'h1);
    @(negedge clk);
    #1;
`ifdef ROM_ARBITER_FIXED_PRIO_EN
    chk("wrap_gnt_next", 32'(gnt1), 32'h1);
`else
    chk("wrap_gnt_next", 32'(gnt1), 32'h8);
`endif

    // Idle hold after a grant to 0x2A.
    @(negedge clk);
    req = 4'b0001;
    set_addr(0, 8'h2A);
    #1;
    chk("idle_gnt", 32'(gnt1), 32'h1);
    chk("idle_addr", 32'(rom_addr1), 32'h2A);
    @(negedge clk);
    req = 4'b0000;
    #1;
    chk("idle_rsp_first", 32'(rsp_valid1), 32'h1);
    chk("idle_addr_first", 32'(rom_addr1), 32'h2A);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("idle_addr%0d", i), 32'(rom_addr1), 32'h2A);
      chk($sformatf("idle_gnt%0d", i), 32'(gnt1), 32'h0);
      chk($sformatf("idle_rsp%0d", i), 32'(rsp_valid1), 32'h0);
    end
    @(negedge clk);
    req = 4'b1111;
    #1;
`ifdef ROM_ARBITER_FIXED_PRIO_EN
    chk("idle_ptr_hold", 32'(gnt1), 32'h1);
`else
    chk("idle_ptr_hold", 32'(gnt1), 32'h2);
`endif

    // Reset mid-flight on the 3-cycle-latency instance.
    @(negedge clk);
    req   = 4'b0000;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0001;
    set_addr(0, 8'h33);
    #1;
    chk("mid_gnt", 32'(gnt3), 32'h1);
    @(negedge clk);
    req   = 4'b0000;
    rst_n = 1'b0;
    #1;
    chk("mid_busy_before", 32'(busy3), 32'h1);
    chk("mid_gnt_in_rst", 32'(gnt3), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_busy_after", 32'(busy3), 32'h0);
    chk("mid_rsp_after", 32'(rsp_valid3), 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("mid_rsp%0d", i), 32'(rsp_valid3), 32'h0);
      chk($sformatf("mid_busy%0d", i), 32'(busy3), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one ROM, range 2..8.
REQ-002 Parameter ADDRW, default 8: ROM address width.
REQ-003 Parameter WIDTH, default 8: ROM data width.
REQ-004 Parameter ROM_LAT, default 1: ROM read latency in clocks, range 1..4.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 req  input  NREQ  per-requester read request, held high until granted.
REQ-008 req_addr  input  NREQ*ADDRW  flattened request addresses; requester i occupies bits [i*ADDRW +: ADDRW].
REQ-009 gnt  output  NREQ  one-hot grant, combinational, same cycle as the winning request.
REQ-010 rom_addr  output  ADDRW  address driven to the ROM.
REQ-011 rom_data  input  WIDTH  ROM read data, valid ROM_LAT cycles after rom_addr is sampled.
REQ-012 rsp_valid  output  NREQ  one-hot, marks the requester that owns rsp_data this cycle.
REQ-013 rsp_data  output  WIDTH  equals rom_data.
REQ-014 busy  output  1  high while any read is in flight in the latency pipeline.

Function
REQ-015 At most one gnt bit is high per cycle, and only for a requester whose req is high.
REQ-016 Round-robin arbitration: the search starts at pointer ptr and wraps modulo NREQ. The first requester at or after ptr with req high wins.
REQ-017 After a grant to requester i, ptr <= (i+1) mod NREQ. If no grant is issued, ptr holds.
REQ-018 rom_addr = req_addr of the granted requester. With no grant, rom_addr holds its previous value.
REQ-019 A tag pipeline ROM_LAT stages deep carries the one-hot gnt vector. rsp_valid = the output of the final stage, exactly ROM_LAT cycles after gnt.
REQ-020 One grant per cycle is allowed. Back-to-back grants produce back-to-back rsp_valid with no bubbles.
REQ-021 A requester may re-request in the cycle after its grant. It is then arbitrated normally under the ptr rotation.
REQ-022 Simultaneous requests from all NREQ requesters are served within NREQ consecutive cycles, one each, in ptr order.
REQ-023 busy = OR of all valid bits held in the tag pipeline.
REQ-024 A change in req_addr while req is high and not yet granted has no effect other than the new address being used at grant.

Reset
REQ-025 While rst_n is low at a clock edge: ptr <= 0, every tag pipeline stage <= 0, and the rom_addr register <= 0.
REQ-026 While rst_n is low, gnt SHALL be forced to 0 combinationally.
REQ-027 Reset asserted mid-operation discards all in-flight reads. rsp_valid is 0 from the first edge with rst_n low, and no stale response appears after release.
REQ-028 In the first cycle after release, requester 0 has highest priority.

Configuration
REQ-029 Macro ROM_ARBITER_FIXED_PRIO_EN selects the arbitration scheme.
- Defined: requester 0 always wins when requesting; the remaining requesters round-robin among themselves, with ptr ranging over 1..NREQ-1 only.
- Undefined: pure round-robin as in REQ-016/017.
REQ-030 All other behaviour, latency and reset values are identical with and without ROM_ARBITER_FIXED_PRIO_EN.

Verification
REQ-031 Single request:
- Stimulus: req=0001, addr0=0x10, ROM_LAT=1.
- Response: gnt=0001 same cycle; rom_addr=0x10; next cycle rsp_valid=0001, rsp_data=mem[0x10].
REQ-032 Full contention:
- Stimulus: req=1111 held for 4 cycles after reset.
- Response: gnt sequence 0001,0010,0100,1000; rsp_valid the same sequence delayed 1 cycle.
REQ-033 Pointer wrap:
- Stimulus: grant to requester 3, then req=1001.
- Response: the next gnt is 0001 (wrap), then 1000.
REQ-034 Reset mid-flight:
- Stimulus: ROM_LAT=3; grant issued; rst_n low one cycle later for 1 cycle.
- Response: no rsp_valid in any subsequent cycle; busy=0 after the reset edge.
REQ-035 Fixed priority, ROM_ARBITER_FIXED_PRIO_EN defined:
- Stimulus: req=1111 held.
- Response: gnt=0001 every cycle. After req[0] drops, gnt cycles 0010,0100,1000.
REQ-036 Idle hold:
- Stimulus: req=0000 for 5 cycles after a grant to address 0x2A.
- Response: rom_addr stays 0x2A, gnt=0, rsp_valid=0, ptr unchanged.
